// File: rtl/weight_preload_rx_pkg.sv
// weight_preload_rx_pkg: shared state encoding and default memory latency for the weight preload receiver.
package weight_preload_rx_pkg;
   typedef enum logic [1:0] {EMPTY = 2'd0, LOADING = 2'd1, READY = 2'd2} load_state_t;
   localparam int DEFAULT_MEM_READ_DELAY = 2;
endpackage

// File: rtl/weight_preload_rx_ctrl_delay_line.sv
// ctrl_delay_line: DEPTH-stage register line that aligns request control with returning memory data.
module ctrl_delay_line
   import weight_preload_rx_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = DEFAULT_MEM_READ_DELAY
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] stage [DEPTH];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end
   assign q = stage[DEPTH-1];
endmodule

// File: rtl/weight_preload_rx.sv
// weight_preload_rx: captures N*N weights returned by memory into a parallel bus and tracks load completeness.
module weight_preload_rx
   import weight_preload_rx_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 11,
   parameter int N              = 5,
   parameter int MEM_READ_DELAY = DEFAULT_MEM_READ_DELAY,
   localparam int LOC_W         = $clog2(N*N)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ctrl_WorI,
   input  logic                    ctrl_ram_en,
   input  logic [ADDR_WIDTH-1:0]   ctrl_read_addr,
   input  logic [LOC_W-1:0]        ctrl_weight_location,
   output logic                    mem_en,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic [N*N*DATA_WIDTH-1:0] weight_bus,
   output logic                    weights_valid,
   output logic                    load_busy,
   output logic                    load_err
);
   localparam int NW = N*N;
   localparam logic [LOC_W:0] NW_L = (LOC_W+1)'(NW);
   logic [LOC_W:0] wr;
   logic wr_v, in_range, start, err_nxt;
   logic [LOC_W-1:0] wr_loc;
   logic [NW-1:0] mask, mask_nxt, hit;
   load_state_t state, state_nxt;
   assign mem_en = ctrl_ram_en;
   assign mem_addr = ctrl_read_addr;
   ctrl_delay_line #(.WIDTH(LOC_W+1), .DEPTH(MEM_READ_DELAY)) u_dly (
      .clk (clk),
      .rst (rst),
      .d   ({ctrl_WorI & ctrl_ram_en, ctrl_weight_location}),
      .q   (wr)
   );
   assign {wr_v, wr_loc} = wr;
   assign in_range = {1'b0, wr_loc} < NW_L;
   assign hit = in_range ? NW'(1) << wr_loc : '0;
   assign start = wr_v && state != LOADING;
   assign load_busy = state == LOADING;
   assign weights_valid = state == READY;
   // A new load restarts the mask and error; an idle cycle mid-load is an abort.
   always_comb begin
      mask_nxt = mask;
      err_nxt = load_err;
      state_nxt = state;
      if (start) begin
         mask_nxt = hit;
         err_nxt = !in_range;
      end else if (wr_v) begin
         mask_nxt = mask | hit;
         err_nxt = load_err | !in_range;
      end else if (state == LOADING) begin
         err_nxt = 1'b1;
      end
      if (wr_v) state_nxt = &mask_nxt ? READY : LOADING;
      else if (state == LOADING) state_nxt = EMPTY;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         mask <= '0;
         load_err <= 1'b0;
         weight_bus <= '0;
      end else begin
         state <= state_nxt;
         mask <= mask_nxt;
         load_err <= err_nxt;
         for (int k = 0; k < NW; k++)
            if (wr_v && wr_loc == LOC_W'(k)) weight_bus[k*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
      end
   end
endmodule

// File: doc/weight_preload_rx.md
WEIGHT_PRELOAD_RX -- requirements
Module: weight_preload_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, weight and memory data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, memory address width.
REQ-003 SHALL have parameter N, default 5, kernel side; the block holds N*N weights; LOC_W = $clog2(N*N).
REQ-004 SHALL have parameter MEM_READ_DELAY, default 2, cycles from mem_en/mem_addr to valid mem_rdata.
REQ-005 clk  input  1  single clock; rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 ctrl_WorI  input  1  weight-preload qualifier for the current read request.
REQ-008 ctrl_ram_en  input  1  read request enable.
REQ-009 ctrl_read_addr  input  ADDR_WIDTH  read address.
REQ-010 ctrl_weight_location  input  LOC_W  destination weight index for the current request.
REQ-011 mem_en  output  1  memory read enable, equal to ctrl_ram_en (combinational pass-through).
REQ-012 mem_addr  output  ADDR_WIDTH  memory address, equal to ctrl_read_addr (combinational pass-through).
REQ-013 mem_rdata  input  DATA_WIDTH  read data, valid MEM_READ_DELAY cycles after the request.
REQ-014 weight_bus  output  N*N*DATA_WIDTH  weight k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-015 weights_valid  output  1  high when all N*N weights of the current load are committed.
REQ-016 load_busy  output  1  high while in the LOADING state.
REQ-017 load_err  output  1  sticky error flag.

Function
REQ-018 SHALL delay {ctrl_WorI & ctrl_ram_en, ctrl_weight_location} through an MEM_READ_DELAY-stage register line, giving wr_v and wr_loc aligned with mem_rdata.
REQ-019 SHALL, when wr_v=1 and wr_loc < N*N, write mem_rdata into weight[wr_loc] at the clock edge; the value is visible on weight_bus the next cycle.
REQ-020 SHALL treat wr_v=1 with wr_loc >= N*N as a no-op write that sets load_err.
REQ-021 SHALL keep an N*N-bit loaded mask and set bit wr_loc on each in-range write; a repeated location overwrites the weight without error.
REQ-022 SHALL implement the FSM EMPTY, LOADING, READY; load_busy=1 only in LOADING; weights_valid=1 only in READY.
REQ-023 EMPTY or READY, first cycle with wr_v=1 -> LOADING; the mask is cleared, then the current bit is set; load_err is cleared unless this write is out of range.
REQ-024 LOADING, the edge at which the mask becomes all-ones -> READY; weights_valid rises the cycle after the N*N-th distinct write.
REQ-025 LOADING, wr_v=0 with the mask incomplete -> EMPTY and set load_err (aborted load); weights are retained but weights_valid stays 0.
REQ-026 READY, with wr_v=0, SHALL hold all weights and weights_valid indefinitely.
REQ-027 Out-of-range writes SHALL NOT cause a state transition by themselves beyond REQ-023.

Reset
REQ-028 On rst=1 at a clock edge, the delay line, weights, mask, load_err, weights_valid and load_busy SHALL become 0 and the state SHALL become EMPTY, including mid-load.
REQ-029 Requests in flight in the delay line at reset SHALL be discarded.

Structure
REQ-030 The shared package SHALL hold the state encoding (EMPTY=0, LOADING=1, READY=2) and the default MEM_READ_DELAY constant.
REQ-031 The delay line SHALL be a sub-module, ctrl_delay_line, parameterised by width and depth.

Verification
REQ-032 Reset test: assert rst for 2 cycles -> all outputs are 0; after release, mem_en and mem_addr track the inputs in the same cycle.
REQ-033 Full load test: issue locations 0..24 on consecutive cycles; memory returns loc+1 after 2 cycles -> weights_valid=1 the cycle after the 25th write, weight[k]=k+1, load_err=0.
REQ-034 Out-of-range test: issue locations 3..27 -> locations 25..27 are ignored, load_err=1, and an abort is flagged with weights_valid=0 (locations 0..2 missing).
REQ-035 Abort test: issue locations 0..9, then drop ctrl_WorI -> 2 cycles later the state is EMPTY, load_err=1, weights_valid=0.
REQ-036 Reload test: from READY, start a new 25-write load with data 0xA0+k -> weights_valid falls on the first write, rises again after the 25th write, and weight[k]=0xA0+k.
REQ-037 Reset mid-load test: assert rst after 12 writes -> the next cycle all weights, the mask and the flags are 0 and the state is EMPTY; subsequent in-flight data is not written.
